// File: rtl/perf_counter_unit.sv
// perf_counter_unit: per-core performance counter aggregator.
// Samples pipeline event strobes while a kernel runs, accumulates them into
// wide counters, and raises a sticky `finished` flag once every warp has been
// idle for FINISH_IDLE_CYCLES consecutive cycles.
// Optional feature macro PERF_COUNTER_SATURATE_EN: counters saturate at
// all-ones instead of wrapping.
// All outputs are registered; an event sampled at edge N is visible after N.
module perf_counter_unit #(
  parameter int NUM_WARPS          = 8,
  parameter int COUNTER_WIDTH      = 64,
  parameter int RETIRE_WIDTH       = 4,
  parameter int FINISH_IDLE_CYCLES = 16,
  localparam int RC_W              = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic [NUM_WARPS-1:0]               warp_active,
  input  logic [RC_W-1:0]                    retire_count,
  input  logic [NUM_WARPS-1:0]               decoded_valid,
  input  logic                               eligible,
  input  logic                               issued,
  input  logic [NUM_WARPS-1:0]               stall_waw,
  input  logic [NUM_WARPS-1:0]               stall_war,
  input  logic [NUM_WARPS-1:0]               stall_busy,
  output logic                               finished,
  output logic [COUNTER_WIDTH-1:0]           inst_retired,
  output logic [COUNTER_WIDTH-1:0]           cycles,
  output logic [COUNTER_WIDTH-1:0]           cycles_decoded,
  output logic [COUNTER_WIDTH-1:0]           cycles_eligible,
  output logic [COUNTER_WIDTH-1:0]           cycles_issued,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] per_warp_cycles_decoded,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] per_warp_stalls_waw,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] per_warp_stalls_war,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] per_warp_stalls_busy,
  output logic [1:0]                         dbg_state
);

  localparam int CW     = COUNTER_WIDTH;
  localparam int IDLE_W = $clog2(FINISH_IDLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              finished_q, finished_d;

  logic [CW-1:0] inst_q, inst_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] dec_q, dec_d;
  logic [CW-1:0] elig_q, elig_d;
  logic [CW-1:0] iss_q, iss_d;
  logic [CW-1:0] pw_dec_q  [NUM_WARPS];
  logic [CW-1:0] pw_dec_d  [NUM_WARPS];
  logic [CW-1:0] pw_waw_q  [NUM_WARPS];
  logic [CW-1:0] pw_waw_d  [NUM_WARPS];
  logic [CW-1:0] pw_war_q  [NUM_WARPS];
  logic [CW-1:0] pw_war_d  [NUM_WARPS];
  logic [CW-1:0] pw_busy_q [NUM_WARPS];
  logic [CW-1:0] pw_busy_d [NUM_WARPS];

  logic            count_en;
  logic            any_active;
  logic [RC_W-1:0] retire_eff;
  logic [IDLE_W-1:0] idle_inc;

  // Counter accumulate: saturating or wrapping depending on build.
  function automatic logic [CW-1:0] acc(input logic [CW-1:0] a, input logic [CW-1:0] b);
`ifdef PERF_COUNTER_SATURATE_EN
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    acc = s[CW] ? {CW{1'b1}} : s[CW-1:0];
`else
    acc = a + b;
`endif
  endfunction

  assign any_active = |warp_active;
  assign count_en   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign retire_eff = (retire_count > RC_W'(RETIRE_WIDTH)) ? RC_W'(RETIRE_WIDTH) : retire_count;
  assign idle_inc   = idle_q + IDLE_W'(1);

  // Lifecycle FSM: IDLE -> RUN -> DRAIN -> DONE, with DRAIN able to fall back to RUN.
  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    finished_d = finished_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_active) state_d = S_RUN;
      end
      S_RUN: begin
        if (!any_active) begin
          idle_d = IDLE_W'(1);
          if (FINISH_IDLE_CYCLES == 1) begin
            state_d    = S_DONE;
            finished_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (any_active) begin
          state_d = S_RUN;
          idle_d  = '0;
        end else begin
          idle_d = idle_inc;
          if (idle_inc == IDLE_W'(FINISH_IDLE_CYCLES)) begin
            state_d    = S_DONE;
            finished_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter next-state: accumulate only while the current state is RUN or DRAIN.
  always_comb begin
    inst_d = inst_q;
    cyc_d  = cyc_q;
    dec_d  = dec_q;
    elig_d = elig_q;
    iss_d  = iss_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pw_dec_d[w]  = pw_dec_q[w];
      pw_waw_d[w]  = pw_waw_q[w];
      pw_war_d[w]  = pw_war_q[w];
      pw_busy_d[w] = pw_busy_q[w];
    end
    if (count_en) begin
      cyc_d  = acc(cyc_q, CW'(1));
      inst_d = acc(inst_q, CW'(retire_eff));
      dec_d  = acc(dec_q, CW'(|decoded_valid));
      elig_d = acc(elig_q, CW'(eligible));
      iss_d  = acc(iss_q, CW'(issued));
      for (int w = 0; w < NUM_WARPS; w++) begin
        pw_dec_d[w]  = acc(pw_dec_q[w], CW'(decoded_valid[w]));
        pw_waw_d[w]  = acc(pw_waw_q[w], CW'(stall_waw[w]));
        pw_war_d[w]  = acc(pw_war_q[w], CW'(stall_war[w]));
        pw_busy_d[w] = acc(pw_busy_q[w], CW'(stall_busy[w]));
      end
    end
  end

  // State and counter registers; reset and clear both restart from zero/IDLE.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q    <= S_IDLE;
      idle_q     <= '0;
      finished_q <= 1'b0;
      inst_q     <= '0;
      cyc_q      <= '0;
      dec_q      <= '0;
      elig_q     <= '0;
      iss_q      <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pw_dec_q[w]  <= '0;
        pw_waw_q[w]  <= '0;
        pw_war_q[w]  <= '0;
        pw_busy_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      finished_q <= finished_d;
      inst_q     <= inst_d;
      cyc_q      <= cyc_d;
      dec_q      <= dec_d;
      elig_q     <= elig_d;
      iss_q      <= iss_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pw_dec_q[w]  <= pw_dec_d[w];
        pw_waw_q[w]  <= pw_waw_d[w];
        pw_war_q[w]  <= pw_war_d[w];
        pw_busy_q[w] <= pw_busy_d[w];
      end
    end
  end

  assign finished        = finished_q;
  assign inst_retired    = inst_q;
  assign cycles          = cyc_q;
  assign cycles_decoded  = dec_q;
  assign cycles_eligible = elig_q;
  assign cycles_issued   = iss_q;
  assign dbg_state       = state_q;

  // Flatten per-warp counters warp-major onto the output buses.
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_flat
    assign per_warp_cycles_decoded[g*CW +: CW] = pw_dec_q[g];
    assign per_warp_stalls_waw[g*CW +: CW]     = pw_waw_q[g];
    assign per_warp_stalls_war[g*CW +: CW]     = pw_war_q[g];
    assign per_warp_stalls_busy[g*CW +: CW]    = pw_busy_q[g];
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Testbench for perf_counter_unit: table-driven segments plus hand-written
// sequences for per-warp stalls, DRAIN re-entry, saturation/wrap and reset.
module tb_perf_counter_unit;

  localparam int NW = 8;
  localparam int CW = 64;

  // Clock/reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, clear;
  logic [NW-1:0] warp_active, decoded_valid, stall_waw, stall_war, stall_busy;
  logic [2:0]    retire_count;
  logic          eligible, issued;

  logic               finished;
  logic [CW-1:0]      inst_retired, cycles, cycles_decoded, cycles_eligible, cycles_issued;
  logic [NW*CW-1:0]   pw_dec, pw_waw, pw_war, pw_busy;
  logic [1:0]         dbg_state;

  logic               finished8;
  logic [7:0]         inst8, cyc8, dec8, elig8, iss8;
  logic [NW*8-1:0]    pw_dec8, pw_waw8, pw_war8, pw_busy8;
  logic [1:0]         dbg_state8;

  perf_counter_unit dut (
    .clock(clock), .reset(reset), .clear(clear), .warp_active(warp_active),
    .retire_count(retire_count), .decoded_valid(decoded_valid), .eligible(eligible),
    .issued(issued), .stall_waw(stall_waw), .stall_war(stall_war), .stall_busy(stall_busy),
    .finished(finished), .inst_retired(inst_retired), .cycles(cycles),
    .cycles_decoded(cycles_decoded), .cycles_eligible(cycles_eligible),
    .cycles_issued(cycles_issued), .per_warp_cycles_decoded(pw_dec),
    .per_warp_stalls_waw(pw_waw), .per_warp_stalls_war(pw_war),
    .per_warp_stalls_busy(pw_busy), .dbg_state(dbg_state)
  );

  perf_counter_unit #(.COUNTER_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .clear(clear), .warp_active(warp_active),
    .retire_count(retire_count), .decoded_valid(decoded_valid), .eligible(eligible),
    .issued(issued), .stall_waw(stall_waw), .stall_war(stall_war), .stall_busy(stall_busy),
    .finished(finished8), .inst_retired(inst8), .cycles(cyc8),
    .cycles_decoded(dec8), .cycles_eligible(elig8),
    .cycles_issued(iss8), .per_warp_cycles_decoded(pw_dec8),
    .per_warp_stalls_waw(pw_waw8), .per_warp_stalls_war(pw_war8),
    .per_warp_stalls_busy(pw_busy8), .dbg_state(dbg_state8)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard compare
  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: advance one clock, land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NW-1:0] wa, input logic [2:0] rc, input logic [NW-1:0] dec,
                       input logic el, input logic is);
    warp_active   = wa;
    retire_count  = rc;
    decoded_valid = dec;
    eligible      = el;
    issued        = is;
  endtask

  typedef struct {
    logic          clr;
    logic [NW-1:0] wa;
    logic [2:0]    rc;
    logic [NW-1:0] dec;
    logic          el;
    logic          is;
    int            n;
    logic [CW-1:0] e_cyc;
    logic [CW-1:0] e_inst;
    logic [CW-1:0] e_dec;
    logic [CW-1:0] e_elig;
    logic [CW-1:0] e_iss;
    logic          e_fin;
    logic [1:0]    e_state;
  } vec_t;

  vec_t vecs[11];

  logic [CW-1:0] exp_waw[NW], exp_war[NW], exp_busy[NW], exp_dec[NW];
  logic [7:0]    exp_inst8;

  initial begin
    // IDLE=0 RUN=1 DRAIN=2 DONE=3
    //          clr  wa     rc    dec    el    is    n   cyc inst dec elig iss fin st
    vecs[0]  = '{1'b0, 8'h00, 3'd2, 8'h00, 1'b1, 1'b1, 20,  0,  0,  0,  0,  0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 8'h01, 3'd2, 8'h10, 1'b1, 1'b1,  1,  0,  0,  0,  0,  0, 1'b0, 2'd1};
    vecs[2]  = '{1'b0, 8'h01, 3'd2, 8'h10, 1'b1, 1'b1, 10, 10, 20, 10, 10, 10, 1'b0, 2'd1};
    vecs[3]  = '{1'b0, 8'h00, 3'd2, 8'h10, 1'b1, 1'b1, 15, 25, 50, 25, 25, 25, 1'b0, 2'd2};
    vecs[4]  = '{1'b0, 8'h00, 3'd2, 8'h10, 1'b1, 1'b1,  1, 26, 52, 26, 26, 26, 1'b1, 2'd3};
    vecs[5]  = '{1'b0, 8'hFF, 3'd4, 8'hFF, 1'b1, 1'b1, 10, 26, 52, 26, 26, 26, 1'b1, 2'd3};
    vecs[6]  = '{1'b1, 8'hFF, 3'd4, 8'hFF, 1'b1, 1'b1,  1,  0,  0,  0,  0,  0, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 8'h81, 3'd7, 8'h04, 1'b0, 1'b0,  1,  0,  0,  0,  0,  0, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 8'h81, 3'd7, 8'h04, 1'b0, 1'b0,  3,  3, 12,  3,  0,  0, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 8'h81, 3'd4, 8'h04, 1'b1, 1'b1,  1,  0,  0,  0,  0,  0, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0,  1,  0,  0,  0,  0,  0, 1'b0, 2'd0};

    reset = 1'b1; clear = 1'b0;
    drive(8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    stall_waw = '0; stall_war = '0; stall_busy = '0;
    step(); step();
    chk("reset_cycles", cycles, 0);
    chk("reset_inst", inst_retired, 0);
    chk("reset_finished", {63'd0, finished}, 0);
    chk("reset_state", {62'd0, dbg_state}, 0);
    reset = 1'b0;

    // Table-driven segments
    for (int i = 0; i < 11; i++) begin
      clear = vecs[i].clr;
      drive(vecs[i].wa, vecs[i].rc, vecs[i].dec, vecs[i].el, vecs[i].is);
      repeat (vecs[i].n) step();
      chk($sformatf("v%0d_cycles", i), cycles, vecs[i].e_cyc);
      chk($sformatf("v%0d_inst", i), inst_retired, vecs[i].e_inst);
      chk($sformatf("v%0d_decoded", i), cycles_decoded, vecs[i].e_dec);
      chk($sformatf("v%0d_eligible", i), cycles_eligible, vecs[i].e_elig);
      chk($sformatf("v%0d_issued", i), cycles_issued, vecs[i].e_iss);
      chk($sformatf("v%0d_finished", i), {63'd0, finished}, {63'd0, vecs[i].e_fin});
      chk($sformatf("v%0d_state", i), {62'd0, dbg_state}, {62'd0, vecs[i].e_state});
    end
    clear = 1'b0;

    // Per-warp stalls: warp 3 WAW+busy for 5 counted cycles, warp 0 WAR for 2.
    clear = 1'b1; step(); clear = 1'b0;
    drive(8'h09, 3'd0, 8'h02, 1'b0, 1'b0);
    step();
    stall_waw = 8'h08; stall_busy = 8'h08; stall_war = 8'h01;
    repeat (2) step();
    stall_war = 8'h00;
    repeat (3) step();
    stall_waw = 8'h00; stall_busy = 8'h00;
    repeat (2) step();
    for (int w = 0; w < NW; w++) begin
      exp_waw[w] = 0; exp_war[w] = 0; exp_busy[w] = 0; exp_dec[w] = 0;
    end
    exp_waw[3] = 5; exp_busy[3] = 5; exp_war[0] = 2; exp_dec[1] = 7;
    for (int w = 0; w < NW; w++) begin
      chk($sformatf("pw_waw[%0d]", w), pw_waw[w*CW +: CW], exp_waw[w]);
      chk($sformatf("pw_war[%0d]", w), pw_war[w*CW +: CW], exp_war[w]);
      chk($sformatf("pw_busy[%0d]", w), pw_busy[w*CW +: CW], exp_busy[w]);
      chk($sformatf("pw_dec[%0d]", w), pw_dec[w*CW +: CW], exp_dec[w]);
    end
    chk("stall_seq_cycles", cycles, 7);

    // DRAIN re-entry: idle count reaches 10, one active cycle restarts it.
    drive(8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    repeat (10) step();
    chk("drain10_state", {62'd0, dbg_state}, 2);
    drive(8'h01, 3'd0, 8'h00, 1'b0, 1'b0);
    step();
    chk("reenter_state", {62'd0, dbg_state}, 1);
    drive(8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    repeat (15) step();
    chk("fresh15_finished", {63'd0, finished}, 0);
    chk("fresh15_state", {62'd0, dbg_state}, 2);
    step();
    chk("fresh16_finished", {63'd0, finished}, 1);
    chk("fresh16_state", {62'd0, dbg_state}, 3);
    chk("reentry_cycles", cycles, 34);
    chk("reentry_pw_dec1", pw_dec[1*CW +: CW], 7);

    // 8-bit counter overflow: retire_count=4 for 70 counted cycles.
    clear = 1'b1; step(); clear = 1'b0;
    drive(8'h01, 3'd4, 8'h00, 1'b0, 1'b0);
    step();
    repeat (70) step();
`ifdef PERF_COUNTER_SATURATE_EN
    exp_inst8 = 8'd255;
`else
    exp_inst8 = 8'd24;
`endif
    chk("w8_inst", {56'd0, inst8}, {56'd0, exp_inst8});
    chk("w8_cycles", {56'd0, cyc8}, 70);
    chk("w64_inst", inst_retired, 280);

    // Mid-run reset: no partial accumulation at the reset edge.
    reset = 1'b1;
    step();
    chk("midreset_cycles", cycles, 0);
    chk("midreset_inst", inst_retired, 0);
    chk("midreset_state", {62'd0, dbg_state}, 0);
    chk("midreset_w8_inst", {56'd0, inst8}, 0);
    reset = 1'b0;
    drive(8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    step();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Core-side performance counter aggregator for one compute core.
- Samples per-cycle pipeline event strobes (retire, decode, eligible, issue, per-warp WAW/WAR/busy stalls) and accumulates them into wide counters.
- Detects kernel completion and raises a sticky `finished` flag.
- Output buses are flat and warp-major, and feed the downstream DPI profiler stage directly.

Parameters:
- NUM_WARPS, 8, number of hardware warps; sets the per-warp strobe width and the flat bus width.
- COUNTER_WIDTH, 64, width of every counter.
- RETIRE_WIDTH, 4, maximum instructions retired per cycle.
- FINISH_IDLE_CYCLES, 16, consecutive all-warps-inactive cycles required before `finished` asserts; must be ≥1.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous counter clear and FSM restart
- warp_active  in  NUM_WARPS  per-warp active mask
- retire_count  in  $clog2(RETIRE_WIDTH+1)  instructions retired this cycle
- decoded_valid  in  NUM_WARPS  per-warp decoded instruction valid
- eligible  in  1  at least one warp eligible for issue
- issued  in  1  an instruction issued this cycle
- stall_waw  in  NUM_WARPS  per-warp WAW hazard stall
- stall_war  in  NUM_WARPS  per-warp WAR hazard stall
- stall_busy  in  NUM_WARPS  per-warp functional-unit-busy stall
- finished  out  1  sticky completion flag
- inst_retired, cycles, cycles_decoded, cycles_eligible, cycles_issued  out  COUNTER_WIDTH each  aggregate counters
- per_warp_cycles_decoded, per_warp_stalls_waw, per_warp_stalls_war, per_warp_stalls_busy  out  NUM_WARPS*COUNTER_WIDTH each  warp w occupies bits [w*COUNTER_WIDTH +: COUNTER_WIDTH]

Behaviour:
- Reset and clear: all counters go to 0, `finished` goes to 0, FSM goes to IDLE, idle counter goes to 0.
  - Reset has priority over clear; clear has priority over any event in the same cycle.
  - Reset or clear mid-run takes effect at the next edge with no partial accumulation.
- All outputs are registered. An event sampled at edge N is visible on the outputs after edge N (1-cycle latency).
- FSM states:
  - IDLE: no counting. Moves to RUN when |warp_active.
  - RUN: counting enabled. Moves to DRAIN when warp_active==0; the idle counter loads 1.
  - DRAIN: counting enabled.
    - Any warp_active bit set: back to RUN, idle counter goes to 0.
    - Otherwise the idle counter increments. When it reaches FINISH_IDLE_CYCLES, go to DONE and set `finished`=1 at that edge.
  - DONE: all counters frozen, `finished` held at 1. Only reset or clear leaves DONE (to IDLE).
- Counting rules, applied only in RUN and DRAIN:
  - cycles += 1.
  - inst_retired += retire_count. Values above RETIRE_WIDTH are clamped to RETIRE_WIDTH.
  - cycles_decoded += 1 if |decoded_valid.
  - cycles_eligible += eligible.
  - cycles_issued += issued.
  - Per-warp w: each of the four counters increments on its own strobe bit w. Simultaneous WAW, WAR and busy stalls on one warp each count independently.
- Counting in the transition cycle:
  - The IDLE→RUN cycle itself is not counted.
  - The RUN/DRAIN→DONE transition cycle is counted.
- Strobes in IDLE or DONE are ignored.
- Arithmetic is unsigned, COUNTER_WIDTH wide. Overflow handling is governed by the optional feature below.

Optional Feature:
- Macro: PERF_COUNTER_SATURATE_EN.
- Defined: every counter saturates at all-ones. For inst_retired, if count + retire_count would exceed max, the result is max. A saturated counter stays at max until reset or clear.
- Undefined: every counter wraps modulo 2^COUNTER_WIDTH.
- In both cases, no other behaviour changes.

Test Plan:
- Reset, then idle with warp_active=0 for 20 cycles -> all counters 0, `finished`=0, FSM in IDLE.
- Run with warp_active=8'h01 for 10 cycles, retire_count=2, issued=1 each cycle, then warp_active=0 -> cycles=10+FINISH_IDLE_CYCLES=26, inst_retired=26×2=52 if strobes are held, cycles_issued=26, `finished`=1 exactly 16 cycles after drop.
- In RUN, warp 3 has stall_waw=stall_busy=1 for 5 cycles and warp 0 has stall_war=1 for 2 cycles -> per_warp_stalls_waw[3]=5, per_warp_stalls_busy[3]=5, per_warp_stalls_war[0]=2, all other warp slices 0.
- In DRAIN, idle count at 10, then warp_active re-asserts for 1 cycle -> back to RUN, idle counter restarts; `finished` asserts only after 16 fresh idle cycles.
- In DONE, drive strobes for 10 cycles -> counters unchanged. Assert clear -> all 0 next cycle, `finished`=0, IDLE.
- COUNTER_WIDTH=8 with retire_count=4 for 70 cycles -> with PERF_COUNTER_SATURATE_EN, inst_retired=255; without it, inst_retired=(280 mod 256)=24.
